// File: rtl/exu_wbu_pkg.sv
// Shared definitions for the writeback unit: FSM state encodings, load-size
// codes and the alignment mask helper used by the load formatter.
package exu_wbu_pkg;

    typedef enum logic [1:0] {
        WBU_IDLE     = 2'd0,
        WBU_WAIT_MEM = 2'd1,
        WBU_WRITE    = 2'd2
    } wbu_state_e;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    // Offset bits that must be zero for an access of the given size.
    function automatic logic [3:0] ld_align_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            LD_B:    mask = 4'b0000;
            LD_H:    mask = 4'b0001;
            LD_W:    mask = 4'b0011;
            LD_D:    mask = 4'b0111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/exu_wbu_ldfmt.sv
// Load formatter: shifts the naturally aligned memory word down to the
// addressed byte, extracts the access width, extends it and flags misalignment.
module exu_wbu_ldfmt
    import exu_wbu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [XLEN-1:0]  data_o,
    output logic             misalign_o
);

    logic [XLEN-1:0] shifted_s;
    logic [63:0]     wide_s;
    logic [63:0]     ext_s;
    logic [3:0]      off_ext_s;

    assign shifted_s = rdata_i >> {off_i, 3'b000};
    assign wide_s    = 64'(shifted_s);
    assign off_ext_s = 4'(off_i);

    // Extension is done at 64 bits; truncating to XLEN lets any access as wide
    // as the datapath pass through unchanged.
    always_comb begin
        ext_s = wide_s;
        case (size_i)
            LD_B:    ext_s = {{56{~unsigned_i & wide_s[7]}},  wide_s[7:0]};
            LD_H:    ext_s = {{48{~unsigned_i & wide_s[15]}}, wide_s[15:0]};
            LD_W:    ext_s = {{32{~unsigned_i & wide_s[31]}}, wide_s[31:0]};
            LD_D:    ext_s = wide_s;
            default: ext_s = wide_s;
        endcase
    end

    assign data_o     = ext_s[XLEN-1:0];
    assign misalign_o = |(off_ext_s & ld_align_mask(size_i));

endmodule

// File: rtl/exu_wbu.sv
// Writeback unit: accepts one retiring instruction, waits for load data when
// needed, then issues a one-cycle registered GPR write and retire pulse.
module exu_wbu
    import exu_wbu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OFF_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_is_load,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [OFF_W-1:0]  in_addr_off,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              gpr_w_en,
    output logic [REG_AW-1:0] gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata,
    output logic              retire,
    output logic              misalign
);

    wbu_state_e        state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wb_en_q, wb_en_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              w_en_q, w_en_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              retire_q, retire_d;
    logic              misalign_q, misalign_d;

    logic [XLEN-1:0]   fmt_data_s;
    logic              fmt_mis_s;

    exu_wbu_ldfmt #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_ldfmt (
        .rdata_i    (mem_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .off_i      (off_q),
        .data_o     (fmt_data_s),
        .misalign_o (fmt_mis_s)
    );

    // Next state; write-port values are computed on the edge into WRITE so the
    // outputs are registered and hold their last value outside WRITE.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wb_en_d    = wb_en_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        w_en_d     = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        retire_d   = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            WBU_IDLE: begin
                if (in_valid) begin
                    rd_d    = in_rd;
                    wb_en_d = in_wb_en;
                    size_d  = in_ld_size;
                    uns_d   = in_ld_unsigned;
                    off_d   = in_addr_off;
                    if (in_is_load) begin
                        state_d = WBU_WAIT_MEM;
                    end else begin
                        waddr_d  = in_rd;
                        wdata_d  = in_alu_result;
                        w_en_d   = in_wb_en & (in_rd != {REG_AW{1'b0}});
                        retire_d = 1'b1;
                        state_d  = WBU_WRITE;
                    end
                end else begin
                    state_d = WBU_IDLE;
                end
            end
            WBU_WAIT_MEM: begin
                if (mem_rvalid) begin
                    waddr_d    = rd_q;
                    wdata_d    = fmt_data_s;
                    w_en_d     = wb_en_q & (rd_q != {REG_AW{1'b0}}) & ~fmt_mis_s;
                    retire_d   = 1'b1;
                    misalign_d = fmt_mis_s;
                    state_d    = WBU_WRITE;
                end else begin
                    state_d = WBU_WAIT_MEM;
                end
            end
            WBU_WRITE: state_d = WBU_IDLE;
            default:   state_d = WBU_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WBU_IDLE;
            rd_q       <= {REG_AW{1'b0}};
            wb_en_q    <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            off_q      <= {OFF_W{1'b0}};
            w_en_q     <= 1'b0;
            waddr_q    <= {REG_AW{1'b0}};
            wdata_q    <= {XLEN{1'b0}};
            retire_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wb_en_q    <= wb_en_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            w_en_q     <= w_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            retire_q   <= retire_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready   = (state_q == WBU_IDLE);
    assign mem_rready = (state_q == WBU_WAIT_MEM);
    assign gpr_w_en   = w_en_q;
    assign gpr_waddr  = waddr_q;
    assign gpr_wdata  = wdata_q;
    assign retire     = retire_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_exu_wbu.sv
// Bench for exu_wbu: an XLEN=32 and an XLEN=64 instance run in lockstep on
// shared stimulus and are checked against a byte-level load model.
module tb_exu_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_wb_en = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_is_load = 1'b0;
    logic [1:0]  in_ld_size = 2'd0;
    logic        in_ld_unsigned = 1'b0;
    logic [2:0]  in_addr_off = 3'd0;
    logic [63:0] in_alu_result = 64'd0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    logic        a_in_ready, a_mem_rready, a_w_en, a_retire, a_mis;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_in_ready, b_mem_rready, b_w_en, b_retire, b_mis;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        wb_en;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  off;
        logic [63:0] alu;
        logic [63:0] rdata;
        int          wait_cyc;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        mis32;
        logic        mis64;
    } vec_t;

    always #5 clk = ~clk;

    exu_wbu #(.XLEN(32), .REG_AW(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_wb_en(in_wb_en), .in_rd(in_rd), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_off(in_addr_off[1:0]), .in_alu_result(in_alu_result[31:0]),
        .mem_rvalid(mem_rvalid), .mem_rready(a_mem_rready), .mem_rdata(mem_rdata[31:0]),
        .gpr_w_en(a_w_en), .gpr_waddr(a_waddr), .gpr_wdata(a_wdata),
        .retire(a_retire), .misalign(a_mis)
    );

    exu_wbu #(.XLEN(64), .REG_AW(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_wb_en(in_wb_en), .in_rd(in_rd), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_off(in_addr_off), .in_alu_result(in_alu_result),
        .mem_rvalid(mem_rvalid), .mem_rready(b_mem_rready), .mem_rdata(mem_rdata),
        .gpr_w_en(b_w_en), .gpr_waddr(b_waddr), .gpr_wdata(b_wdata),
        .retire(b_retire), .misalign(b_mis)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference: gather bytes starting at the offset, then extend if narrower than xlen.
    function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] rdata,
                                             input logic [1:0] size, input logic uns,
                                             input logic [2:0] off);
        int nbytes = 1 << size;
        int o = int'(off) % (xlen / 8);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < nbytes; i++) begin
            if (o + i < xlen / 8) v[8*i +: 8] = rdata[8*(o+i) +: 8];
        end
        if (nbytes * 8 < xlen && !uns && v[nbytes*8-1]) begin
            for (int k = nbytes * 8; k < 64; k++) v[k] = 1'b1;
        end
        if (xlen == 32) v[63:32] = 32'd0;
        return v;
    endfunction

    function automatic logic ref_mis(input int xlen, input logic [1:0] size, input logic [2:0] off);
        int o = int'(off) % (xlen / 8);
        return (o % (1 << size)) != 0;
    endfunction

    task automatic wait_ready();
        int i = 0;
        while (!(a_in_ready && b_in_ready) && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("in_ready_timeout", {62'd0, a_in_ready, b_in_ready}, 64'd3);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wen"},    {62'd0, a_w_en, b_w_en}, 64'd0);
        chk({tag, "_retire"}, {62'd0, a_retire, b_retire}, 64'd0);
        chk({tag, "_mis"},    {62'd0, a_mis, b_mis}, 64'd0);
        chk({tag, "_waddr"},  {54'd0, a_waddr, b_waddr}, 64'd0);
        chk({tag, "_wdata32"}, {32'd0, a_wdata}, 64'd0);
        chk({tag, "_wdata64"}, b_wdata, 64'd0);
        chk({tag, "_ready"},  {62'd0, a_in_ready, b_in_ready}, 64'd3);
        chk({tag, "_rready"}, {62'd0, a_mem_rready, b_mem_rready}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic we32, we64;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid       = 1'b1;
        in_wb_en       = v.wb_en;
        in_rd          = v.rd;
        in_is_load     = v.is_load;
        in_ld_size     = v.size;
        in_ld_unsigned = v.uns;
        in_addr_off    = v.off;
        in_alu_result  = v.alu;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v.is_load) begin
            for (int w = 0; w < v.wait_cyc; w++) begin
                mem_rdata = {$urandom, $urandom};
                @(negedge clk);
                chk({tag, "_wait_rready"}, {62'd0, a_mem_rready, b_mem_rready}, 64'd3);
                chk({tag, "_wait_ready"}, {62'd0, a_in_ready, b_in_ready}, 64'd0);
                chk({tag, "_wait_retire"}, {62'd0, a_retire, b_retire}, 64'd0);
                @(posedge clk);
                #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
        end
        we32 = v.wb_en && (v.rd != 5'd0) && !(v.is_load && v.mis32);
        we64 = v.wb_en && (v.rd != 5'd0) && !(v.is_load && v.mis64);
        @(negedge clk);
        chk({tag, "_retire"}, {62'd0, a_retire, b_retire}, 64'd3);
        chk({tag, "_wen"}, {62'd0, a_w_en, b_w_en}, {62'd0, we32, we64});
        chk({tag, "_mis"}, {62'd0, a_mis, b_mis},
            {62'd0, v.is_load && v.mis32, v.is_load && v.mis64});
        chk({tag, "_waddr"}, {54'd0, a_waddr, b_waddr}, {54'd0, v.rd, v.rd});
        if (!(v.is_load && v.mis32)) chk({tag, "_wdata32"}, {32'd0, a_wdata}, v.exp32);
        if (!(v.is_load && v.mis64)) chk({tag, "_wdata64"}, b_wdata, v.exp64);
        chk({tag, "_wr_ready"}, {62'd0, a_in_ready, b_in_ready}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_post_retire"}, {62'd0, a_retire, b_retire, a_w_en, b_w_en}, 64'd0);
        chk({tag, "_post_ready"}, {62'd0, a_in_ready, b_in_ready}, 64'd3);
        chk({tag, "_hold_waddr"}, {54'd0, a_waddr, b_waddr}, {54'd0, v.rd, v.rd});
    endtask

    vec_t tbl[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // {is_load, rd, wb_en, size, uns, off, alu, rdata, wait, exp32, exp64, mis32, mis64}
        tbl[0]  = '{1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 3'd0, 64'hAAAA_0000_1234_5678, 64'd0, 0,
                    64'h0000_0000_1234_5678, 64'hAAAA_0000_1234_5678, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd10, 1'b1, 2'd0, 1'b0, 3'd3, 64'd0, 64'h0000_0000_80FF_FFFF, 4,
                    64'h0000_0000_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd11, 1'b1, 2'd1, 1'b1, 3'd2, 64'd0, 64'h0000_0000_BEEF_0000, 1,
                    64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd12, 1'b1, 2'd2, 1'b1, 3'd4, 64'd0, 64'h8000_0001_1234_5678, 2,
                    64'h0000_0000_1234_5678, 64'h0000_0000_8000_0001, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 3'd0, 64'h0000_0000_0000_0055, 64'd0, 0,
                    64'h55, 64'h55, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd7, 1'b1, 2'd2, 1'b0, 3'd2, 64'd0, 64'h0123_4567_89AB_CDEF, 0,
                    64'd0, 64'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 5'd9, 1'b1, 2'd3, 1'b0, 3'd0, 64'd0, 64'hFEDC_BA98_7654_3210, 3,
                    64'h0000_0000_7654_3210, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5'd13, 1'b1, 2'd1, 1'b0, 3'd2, 64'd0, 64'h1234_5678_8001_0000, 0,
                    64'h0000_0000_FFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd3, 1'b0, 2'd0, 1'b0, 3'd0, 64'h0000_0000_0000_0777, 64'd0, 0,
                    64'h777, 64'h777, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 5'd14, 1'b1, 2'd0, 1'b0, 3'd5, 64'd0, 64'h0000_7F00_0000_0000, 1,
                    64'd0, 64'h0000_0000_0000_007F, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 5'd15, 1'b1, 2'd2, 1'b0, 3'd4, 64'd0, 64'h8000_0000_0000_0000, 2,
                    64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 5'd16, 1'b1, 2'd3, 1'b0, 3'd4, 64'd0, 64'h1111_2222_3333_4444, 0,
                    64'h0000_0000_3333_4444, 64'd0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a load is outstanding; the late response must be dropped.
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_is_load = 1'b1; in_ld_size = 2'd2; in_addr_off = 3'd0;
        in_rd = 5'd6; in_wb_en = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstld_rready", {62'd0, a_mem_rready, b_mem_rready}, 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        check_reset_vals("rstld_a");
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_reset_vals($sformatf("rstld_b%0d", k));
        end

        // Response while idle must not be captured.
        @(posedge clk);
        #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        chk("spur_rready", {62'd0, a_mem_rready, b_mem_rready}, 64'd0);
        chk("spur_retire", {62'd0, a_retire, b_retire}, 64'd0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        v = '{1'b0, 5'd4, 1'b1, 2'd0, 1'b0, 3'd0, 64'h0000_0000_CAFE_F00D, 64'd0, 0,
              64'h0000_0000_CAFE_F00D, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0};
        run_vec(v, "spur_alu");

        for (int n = 0; n < 150; n++) begin
            v.is_load  = 1'($urandom_range(0, 1));
            v.rd       = 5'($urandom);
            v.wb_en    = 1'($urandom_range(0, 3) != 0);
            v.size     = 2'($urandom);
            v.uns      = 1'($urandom);
            v.off      = 3'($urandom);
            if ($urandom_range(0, 1) == 0) v.off = v.off & ~3'((1 << v.size) - 1);
            v.alu      = {$urandom, $urandom};
            v.rdata    = {$urandom, $urandom};
            v.wait_cyc = $urandom_range(0, 5);
            if (v.is_load) begin
                v.exp32 = ref_load(32, v.rdata, v.size, v.uns, v.off);
                v.exp64 = ref_load(64, v.rdata, v.size, v.uns, v.off);
                v.mis32 = ref_mis(32, v.size, v.off);
                v.mis64 = ref_mis(64, v.size, v.off);
            end else begin
                v.exp32 = {32'd0, v.alu[31:0]};
                v.exp64 = v.alu;
                v.mis32 = 1'b0;
                v.mis64 = 1'b0;
            end
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
